// File: rtl/npc_trap_unit_pkg.sv
// Shared encodings for the next-PC / trap unit: NPC op codes,
// exception codes, EXL states and the SCAUSE interrupt-flag position.
package npc_trap_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4   = 3'b000,
    NPC_BRANCH  = 3'b001,
    NPC_JUMP    = 3'b010,
    NPC_INT_RET = 3'b011,
    NPC_JALR    = 3'b100
  } npc_op_e;

  typedef enum logic [3:0] {
    EXC_ILLEGAL = 4'd2,
    EXC_ECALL   = 4'd8
  } exc_code_e;

  typedef enum logic {
    EXL_NORMAL  = 1'b0,
    EXL_IN_TRAP = 1'b1
  } exl_state_e;

  localparam int IRQ_IDX_W = 4;

  function automatic int scause_irq_bit(int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/npc_trap_unit_irq_prio_enc.sv
// Fixed-priority interrupt encoder: lowest set index wins.
// Reports whether any masked-in source is pending.
module irq_prio_enc
  import npc_trap_unit_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]   req_i,
  output logic                 any_o,
  output logic [IRQ_IDX_W-1:0] idx_o
);

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/npc_trap_unit.sv
// Next-PC generator with PC register and single-level trap controller.
// Optional NPC_TRAP_TVAL_EN adds exc_tval input and stval register.
module npc_trap_unit
  import npc_trap_unit_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NUM_IRQ   = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_BASE = 'h0000_0a7c,
  parameter bit              VECTORED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic [2:0]         npc_op,
  input  logic [XLEN-1:0]    pc_ex,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    alu_out,
  input  logic               exc_valid,
  input  logic [3:0]         exc_code,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    npc,
  output logic               trap_taken,
  output logic               exl,
  output logic [XLEN-1:0]    sepc,
  output logic [XLEN-1:0]    scause
`ifdef NPC_TRAP_TVAL_EN
  ,
  input  logic [XLEN-1:0]    exc_tval,
  output logic [XLEN-1:0]    stval
`endif
);

  localparam int IRQ_BIT = scause_irq_bit(XLEN);

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      sepc_q, sepc_d;
  logic [XLEN-1:0]      scause_q, scause_d;
  logic [XLEN-1:0]      vec;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [NUM_IRQ-1:0]   irq_q, irq_clr;
  logic                 any;
  logic [IRQ_IDX_W-1:0] idx;
  logic                 trap_exc, trap_irq, trap;
  logic                 is_ret;
  exl_state_e           st_q, st_d;

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_enc (
    .req_i(pend_q & irq_mask),
    .any_o(any),
    .idx_o(idx)
  );

  assign trap_exc = pc_write & exc_valid;
  assign trap_irq = pc_write & ~exc_valid & any
                  & (st_q == EXL_NORMAL);
  assign trap     = trap_exc | trap_irq;
  assign is_ret   = pc_write & ~trap
                  & (npc_op == NPC_INT_RET);

  always_comb begin
    vec = TRAP_BASE;
    if (VECTORED && trap_irq)
      vec = TRAP_BASE + XLEN'({idx, 2'b00});
  end

  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (!pc_write) begin
      pc_d = pc_q;
    end else if (trap) begin
      pc_d = vec;
    end else begin
      case (npc_op)
        NPC_BRANCH,
        NPC_JUMP:    pc_d = pc_ex + imm;
        NPC_JALR:    pc_d = alu_out;
        NPC_INT_RET: pc_d = scause_q[IRQ_BIT] ? sepc_q
                                              : sepc_q + XLEN'(4);
        default:     pc_d = pc_q + XLEN'(4);
      endcase
    end
  end

  // A new rising edge on the same line as the taken IRQ re-arms it.
  always_comb begin
    irq_clr = '0;
    if (trap_irq) irq_clr = NUM_IRQ'(1) << idx;
    pend_d = (pend_q & ~irq_clr) | (irq_req & ~irq_q);
  end

  always_comb begin
    sepc_d   = sepc_q;
    scause_d = scause_q;
    if (trap) sepc_d = pc_ex;
    if (trap_exc)
      scause_d = XLEN'(exc_code);
    else if (trap_irq)
      scause_d = (XLEN'(1) << IRQ_BIT) | XLEN'(idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      irq_q    <= '0;
      sepc_q   <= '0;
      scause_q <= '0;
    end else begin
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      irq_q    <= irq_req;
      sepc_q   <= sepc_d;
      scause_q <= scause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= EXL_NORMAL;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      EXL_NORMAL:  if (trap) st_d = EXL_IN_TRAP;
      EXL_IN_TRAP: if (!trap && is_ret) st_d = EXL_NORMAL;
      default:     st_d = EXL_NORMAL;
    endcase
  end

  always_comb begin
    exl = (st_q == EXL_IN_TRAP);
  end

`ifdef NPC_TRAP_TVAL_EN
  logic [XLEN-1:0] stval_q, stval_d;

  always_comb begin
    stval_d = stval_q;
    if (trap_exc)      stval_d = exc_tval;
    else if (trap_irq) stval_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) stval_q <= '0;
    else     stval_q <= stval_d;
  end

  assign stval = stval_q;
`endif

  assign pc         = pc_q;
  assign npc        = pc_d;
  assign trap_taken = trap & ~rst;
  assign sepc       = sepc_q;
  assign scause     = scause_q;

endmodule

// File: tb/tb_npc_trap_unit.sv
// Randomised + directed bench for npc_trap_unit, direct and vectored
// instances checked against a behavioural trap model.
module tb_npc_trap_unit;
  import npc_trap_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [2:0]  npc_op;
  logic [31:0] pc_ex, imm, alu_out;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [7:0]  irq_req, irq_mask;

  logic [31:0] o_pc [2];
  logic [31:0] o_npc [2];
  logic        o_tt [2];
  logic        o_exl [2];
  logic [31:0] o_sepc [2];
  logic [31:0] o_scause [2];
`ifdef NPC_TRAP_TVAL_EN
  logic [31:0] exc_tval;
  logic [31:0] o_stval [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] BASE = 32'h0000_0a7c;

  always #5 clk = ~clk;

  npc_trap_unit #(.VECTORED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .npc_op(npc_op), .pc_ex(pc_ex), .imm(imm),
    .alu_out(alu_out), .exc_valid(exc_valid),
    .exc_code(exc_code), .irq_req(irq_req),
    .irq_mask(irq_mask), .pc(o_pc[0]), .npc(o_npc[0]),
    .trap_taken(o_tt[0]), .exl(o_exl[0]),
    .sepc(o_sepc[0]), .scause(o_scause[0])
`ifdef NPC_TRAP_TVAL_EN
    , .exc_tval(exc_tval), .stval(o_stval[0])
`endif
  );

  npc_trap_unit #(.VECTORED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .npc_op(npc_op), .pc_ex(pc_ex), .imm(imm),
    .alu_out(alu_out), .exc_valid(exc_valid),
    .exc_code(exc_code), .irq_req(irq_req),
    .irq_mask(irq_mask), .pc(o_pc[1]), .npc(o_npc[1]),
    .trap_taken(o_tt[1]), .exl(o_exl[1]),
    .sepc(o_sepc[1]), .scause(o_scause[1])
`ifdef NPC_TRAP_TVAL_EN
    , .exc_tval(exc_tval), .stval(o_stval[1])
`endif
  );

  // Behavioural model state, one copy per instance.
  logic [31:0] m_pc [2];
  logic [31:0] m_sepc [2];
  logic [31:0] m_scause [2];
  logic [31:0] m_stval [2];
  bit          m_exl [2];
  bit [7:0]    m_pend [2];
  bit [7:0]    m_prev;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    logic [31:0] e_npc [2];
    bit          e_tx [2];
    bit          e_ti [2];
    int          e_idx [2];
    bit [7:0]    rise;
    @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      e_idx[v] = -1;
      for (int i = 0; i < 8; i++)
        if (e_idx[v] < 0 && m_pend[v][i] && irq_mask[i])
          e_idx[v] = i;
      e_tx[v] = pc_write && exc_valid;
      e_ti[v] = pc_write && !exc_valid && e_idx[v] >= 0
              && !m_exl[v];
      if (!pc_write) e_npc[v] = m_pc[v];
      else if (e_ti[v] && v == 1)
        e_npc[v] = BASE + 32'(4 * e_idx[v]);
      else if (e_tx[v] || e_ti[v]) e_npc[v] = BASE;
      else if (npc_op == 3'b001 || npc_op == 3'b010)
        e_npc[v] = pc_ex + imm;
      else if (npc_op == 3'b100) e_npc[v] = alu_out;
      else if (npc_op == 3'b011)
        e_npc[v] = m_scause[v][31] ? m_sepc[v]
                                   : m_sepc[v] + 32'd4;
      else e_npc[v] = m_pc[v] + 32'd4;
      if (rst) begin
        chk($sformatf("tt_rst%0d", v), 32'(o_tt[v]), 32'd0);
      end else begin
        chk($sformatf("npc%0d", v), o_npc[v], e_npc[v]);
        chk($sformatf("tt%0d", v), 32'(o_tt[v]),
            32'(e_tx[v] || e_ti[v]));
      end
    end
    @(posedge clk);
    #1;
    rise = irq_req & ~m_prev;
    for (int v = 0; v < 2; v++) begin
      if (rst) begin
        m_pc[v] = 32'd0; m_sepc[v] = 32'd0;
        m_scause[v] = 32'd0; m_stval[v] = 32'd0;
        m_exl[v] = 1'b0; m_pend[v] = 8'd0;
      end else begin
        if (e_ti[v]) m_pend[v][e_idx[v]] = 1'b0;
        m_pend[v] = m_pend[v] | rise;
        if (pc_write) m_pc[v] = e_npc[v];
        if (e_tx[v]) begin
          m_sepc[v] = pc_ex;
          m_scause[v] = {28'd0, exc_code};
`ifdef NPC_TRAP_TVAL_EN
          m_stval[v] = exc_tval;
`endif
          m_exl[v] = 1'b1;
        end else if (e_ti[v]) begin
          m_sepc[v] = pc_ex;
          m_scause[v] = 32'h8000_0000 | 32'(e_idx[v]);
          m_stval[v] = 32'd0;
          m_exl[v] = 1'b1;
        end else if (pc_write && npc_op == 3'b011) begin
          m_exl[v] = 1'b0;
        end
      end
      chk($sformatf("pc%0d", v), o_pc[v], m_pc[v]);
      chk($sformatf("exl%0d", v), 32'(o_exl[v]),
          32'(m_exl[v]));
      chk($sformatf("sepc%0d", v), o_sepc[v], m_sepc[v]);
      chk($sformatf("scause%0d", v), o_scause[v],
          m_scause[v]);
`ifdef NPC_TRAP_TVAL_EN
      chk($sformatf("stval%0d", v), o_stval[v], m_stval[v]);
`endif
    end
    m_prev = rst ? 8'd0 : irq_req;
  endtask

  task automatic drv(bit pw, logic [2:0] op);
    pc_write = pw;
    npc_op = op;
  endtask

  initial begin
    rst = 1'b1; pc_write = 1'b1; npc_op = 3'b000;
    pc_ex = '0; imm = '0; alu_out = '0;
    exc_valid = 1'b0; exc_code = '0;
    irq_req = '0; irq_mask = '0;
`ifdef NPC_TRAP_TVAL_EN
    exc_tval = 32'hdead_beef;
`endif
    m_prev = '0;
    for (int v = 0; v < 2; v++) begin
      m_pc[v] = 'x; m_sepc[v] = 'x; m_scause[v] = 'x;
      m_stval[v] = 'x; m_exl[v] = 1'b0; m_pend[v] = '0;
    end
    cyc();
    cyc();
    chk("rst_pc", o_pc[0], 32'd0);
    chk("rst_exl", 32'(o_exl[1]), 32'd0);

    rst = 1'b0;
    drv(1, NPC_PLUS4);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("plus4", o_pc[0], 32'(4 * k));
    end

    drv(1, NPC_BRANCH); pc_ex = 32'h100; imm = 32'h20;
    cyc();
    chk("branch", o_pc[0], 32'h120);
    drv(0, NPC_PLUS4);
    cyc();
    cyc();
    chk("stall", o_pc[1], 32'h120);

    drv(1, NPC_PLUS4); pc_ex = 32'h40;
    exc_valid = 1'b1; exc_code = EXC_ECALL;
    cyc();
    chk("exc_pc", o_pc[0], BASE);
    chk("exc_cause", o_scause[0], 32'd8);
    exc_valid = 1'b0; drv(1, NPC_INT_RET);
    cyc();
    chk("ret_pc", o_pc[0], 32'h44);

    irq_mask = 8'hff; irq_req = 8'h28;
    drv(1, NPC_PLUS4); pc_ex = 32'h200;
    cyc();
    cyc();
    chk("irq3_pc", o_pc[1], BASE + 32'd12);
    chk("irq3_cause", o_scause[1], 32'h8000_0003);
    drv(1, NPC_INT_RET); pc_ex = 32'h300;
    cyc();
    chk("iret_pc", o_pc[1], 32'h200);
    drv(1, NPC_PLUS4); pc_ex = 32'h204;
    cyc();
    chk("irq5_pc", o_pc[1], BASE + 32'd20);
    chk("irq5_cause", o_scause[1], 32'h8000_0005);

    irq_req = 8'h29;
    cyc();
    cyc();
    chk("exl_hold", 32'(o_exl[0]), 32'd1);
    drv(1, NPC_INT_RET);
    cyc();
    drv(1, NPC_PLUS4);
    cyc();
    chk("irq0_cause", o_scause[1], 32'h8000_0000);

    drv(1, NPC_INT_RET);
    cyc();
    irq_req = 8'h2b; drv(1, NPC_PLUS4); pc_ex = 32'h500;
    cyc();
    exc_valid = 1'b1; exc_code = EXC_ILLEGAL;
    cyc();
    chk("exc_win", o_scause[1], 32'd2);
    exc_valid = 1'b0; drv(1, NPC_INT_RET);
    cyc();
    chk("exc_ret", o_pc[1], 32'h504);
    drv(1, NPC_PLUS4);
    cyc();
    chk("irq1_kept", o_scause[1], 32'h8000_0001);
    rst = 1'b1;
    cyc();
    chk("rst_trap_pc", o_pc[1], 32'd0);
    chk("rst_trap_exl", 32'(o_exl[1]), 32'd0);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(99) == 0);
      pc_write = ($urandom_range(7) != 0);
      npc_op = ($urandom_range(3) == 0) ? 3'b011
                                        : 3'($urandom);
      exc_valid = ($urandom_range(9) == 0);
      exc_code = 4'($urandom);
      if ($urandom_range(2) == 0)
        irq_req = irq_req ^ 8'(1 << $urandom_range(7));
      if ($urandom_range(7) == 0) irq_mask = 8'($urandom);
      pc_ex = $urandom; imm = $urandom; alu_out = $urandom;
`ifdef NPC_TRAP_TVAL_EN
      exc_tval = $urandom;
`endif
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
